quad_step_decoder: RTL and testbench

- Quadrature input decoder that drives an up/down position count from A/B encoder channels; produces the enable and direction stimulus that the team's up/down counter consumes.
- Synchronises and glitch-filters both channels, decodes Gray-code transitions into single-cycle step pulses with direction, and keeps a loadable wrap-around position count.
- Flags illegal double-bit transitions.
- Sits between an external encoder pins block and downstream position/control logic.

---
 rtl/quad_step_decoder.sv | 135 +++++++++++++
 tb/tb_quad_step_decoder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_step_decoder.sv
// quad_step_decoder
// Quadrature encoder front end: synchronises and glitch-filters the A/B
// channels, decodes Gray-code transitions into single-cycle step pulses
// with a direction flag, and keeps a loadable wrap-around position count.
// Double-bit transitions set a sticky error flag.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   enable   in   1: legal steps move count / pulse step; 0: decode only
//   load     in   synchronous load of data_in into count (wins over a step)
//   data_in  in   [WIDTH-1:0] load value
//   quad_a   in   encoder channel A (asynchronous)
//   quad_b   in   encoder channel B (asynchronous)
//   err_clr  in   clears err (a same-cycle new error wins)
//   count    out  [WIDTH-1:0] position count, wraps modulo 2^WIDTH
//   step     out  one-cycle pulse per accepted legal transition
//   dir      out  direction of last accepted step (0 up, 1 down)
//   err      out  sticky illegal-transition flag
module quad_step_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] count,
  output logic             step,
  output logic             dir,
  output logic             err
);

  // The filter window is the live synchroniser output plus FILTER_LEN-1
  // older samples held in hist_q.
  localparam int HIST_LEN = (FILTER_LEN > 1) ? FILTER_LEN - 1 : 1;
  // Edges after reset before the window holds only post-reset input samples.
  localparam int FILL_MAX = SYNC_STAGES + FILTER_LEN - 1;
  localparam int FILL_W   = $clog2(FILL_MAX + 1);

  logic [SYNC_STAGES-1:0] sync_a_q;
  logic [SYNC_STAGES-1:0] sync_b_q;
  logic [1:0]             hist_q [HIST_LEN];
  logic [FILL_W-1:0]      fill_q;
  logic [1:0]             ab_q;
  logic                   primed_q;
  logic [WIDTH-1:0]       count_q, count_d;
  logic                   step_q, step_d;
  logic                   dir_q, dir_d;
  logic                   err_q, err_d;

  logic [1:0] sync_ab;
  logic       stable;
  logic       fill_done;
  logic       upd;
  logic       mv_up, mv_dn, mv_bad;

  // Up sequence in {A,B}: 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic is_up(input logic [1:0] from_ab, input logic [1:0] to_ab);
    case (from_ab)
      2'b00:   is_up = (to_ab == 2'b10);
      2'b10:   is_up = (to_ab == 2'b11);
      2'b11:   is_up = (to_ab == 2'b01);
      default: is_up = (to_ab == 2'b00);
    endcase
  endfunction

  assign sync_ab   = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};
  assign fill_done = (fill_q == FILL_W'(FILL_MAX));

  always_comb begin
    stable = 1'b1;
    for (int i = 0; i < FILTER_LEN - 1; i++) begin
      if (hist_q[i] != sync_ab) stable = 1'b0;
    end
  end

  // Until primed, the first settled value (once the pipeline has refilled
  // after reset) is captured silently; afterwards only changes count.
  assign upd    = stable && (primed_q ? (sync_ab != ab_q) : fill_done);
  assign mv_up  = is_up(ab_q, sync_ab);
  assign mv_dn  = is_up(sync_ab, ab_q);
  assign mv_bad = ((ab_q ^ sync_ab) == 2'b11);

  always_comb begin
    step_d  = upd && primed_q && (mv_up || mv_dn) && enable;
    dir_d   = step_d ? mv_dn : dir_q;
    count_d = count_q;
    if (step_d) count_d = mv_dn ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
    if (load)   count_d = data_in;
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (upd && primed_q && mv_bad) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a_q <= '0;
      sync_b_q <= '0;
      for (int i = 0; i < HIST_LEN; i++) hist_q[i] <= 2'b00;
      fill_q   <= '0;
      ab_q     <= 2'b00;
      primed_q <= 1'b0;
      count_q  <= '0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], quad_a};
      sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], quad_b};
      hist_q[0] <= sync_ab;
      for (int i = 1; i < HIST_LEN; i++) hist_q[i] <= hist_q[i-1];
      if (!fill_done) fill_q <= fill_q + FILL_W'(1);
      if (upd) begin
        ab_q     <= sync_ab;
        primed_q <= 1'b1;
      end
      count_q <= count_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  assign count = count_q;
  assign step  = step_q;
  assign dir   = dir_q;
  assign err   = err_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
module tb_quad_step_decoder;

  localparam int W  = 4;
  localparam int SS = 2;
  localparam int FL = 3;

  logic         clk = 1'b0;
  logic         rst, enable, load, err_clr, quad_a, quad_b;
  logic [W-1:0] data_in;
  logic [W-1:0] count;
  logic         step, dir, err;

  quad_step_decoder #(.WIDTH(W), .SYNC_STAGES(SS), .FILTER_LEN(FL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .load(load), .data_in(data_in),
    .quad_a(quad_a), .quad_b(quad_b), .err_clr(err_clr),
    .count(count), .step(step), .dir(dir), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: input samples per clock edge since reset release,
  // decoded by quadrant position arithmetic.
  logic [1:0]   sq[$];
  logic [1:0]   m_ab;
  bit           m_primed;
  logic [W-1:0] m_count;
  bit           m_step, m_dir, m_err;
  int           step_seen;

  function automatic int gpos(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] genc(input int p);
    case (p % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic model_reset();
    sq.delete();
    m_ab = 2'b00; m_primed = 0; m_count = '0;
    m_step = 0; m_dir = 0; m_err = 0;
  endtask

  task automatic model_edge();
    logic [1:0]   win;
    logic [W-1:0] nc;
    bit           stbl, eset;
    int           t, d;
    sq.push_back({quad_a, quad_b});
    t = sq.size();
    stbl = 0; eset = 0; m_step = 0; nc = m_count; win = 2'b00;
    // Window: samples of edges t-SS-FL+1 .. t-SS, all must exist.
    if (t >= SS + FL) begin
      win = sq[t-SS-1];
      stbl = 1;
      for (int k = t - SS - FL + 1; k <= t - SS; k++)
        if (sq[k-1] != win) stbl = 0;
    end
    if (stbl && !m_primed) begin
      m_primed = 1; m_ab = win;
    end else if (stbl && win != m_ab) begin
      d = (gpos(win) - gpos(m_ab) + 4) % 4;
      m_ab = win;
      if (d == 2) eset = 1;
      else if (enable) begin
        m_step = 1;
        m_dir  = (d == 3);
        nc     = (d == 1) ? m_count + 1'b1 : m_count - 1'b1;
      end
    end
    if (load) nc = data_in;
    m_count = nc;
    if (eset) m_err = 1;
    else if (err_clr) m_err = 0;
  endtask

  task automatic cmp_outputs();
    check_eq("count", count, m_count);
    check_eq("step", step, m_step);
    check_eq("dir", dir, m_dir);
    check_eq("err", err, m_err);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (!rst) model_edge();
    cmp_outputs();
    if (step) step_seen++;
  endtask

  task automatic hold(input int n);
    repeat (n) cyc();
  endtask

  task automatic set_ab(input logic [1:0] v);
    quad_a = v[1];
    quad_b = v[0];
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("rst_count", count, 0);
    check_eq("rst_step", step, 0);
    check_eq("rst_dir", dir, 0);
    check_eq("rst_err", err, 0);
    hold(n);
    rst = 1'b0;
  endtask

  task automatic rcyc();
    load    = ($urandom_range(0, 19) == 0);
    data_in = W'($urandom);
    err_clr = ($urandom_range(0, 9) == 0);
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, p, r, g;
    logic [1:0] upseq [4];
    logic [1:0] dnseq [4];
    upseq[0] = 2'b10; upseq[1] = 2'b11; upseq[2] = 2'b01; upseq[3] = 2'b00;
    dnseq[0] = 2'b01; dnseq[1] = 2'b11; dnseq[2] = 2'b10; dnseq[3] = 2'b00;
    enable = 1'b1; load = 1'b0; err_clr = 1'b0; data_in = '0;
    quad_a = 1'b0; quad_b = 1'b0; step_seen = 0;
    do_reset(2);

    // Prime at 00.
    hold(10);
    check_eq("prime_steps", step_seen, 0);
    check_eq("prime_count", count, 0);
    check_eq("prime_err", err, 0);

    // Four full up cycles with latency check on each step.
    step_seen = 0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        set_ab(upseq[i]);
        lat = 0;
        do begin cyc(); lat++; end while (!step && lat < 20);
        check_eq("latency", lat, 5);
        hold(7);
      end
    end
    check_eq("up_steps", step_seen, 16);
    check_eq("up_count", count, 0);
    check_eq("up_dir", dir, 0);

    // One down cycle from 0.
    step_seen = 0;
    for (int i = 0; i < 4; i++) begin
      set_ab(dnseq[i]);
      hold(8);
      check_eq("dn_count", count, 15 - i);
    end
    check_eq("dn_steps", step_seen, 4);
    check_eq("dn_dir", dir, 1);

    // Illegal jump, clear, then clear coinciding with a new error.
    step_seen = 0;
    set_ab(2'b11);
    hold(8);
    check_eq("ill_err", err, 1);
    check_eq("ill_count", count, 12);
    check_eq("ill_steps", step_seen, 0);
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    check_eq("clr_err", err, 0);
    set_ab(2'b00);
    hold(4);
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    check_eq("setwins_err", err, 1);
    hold(4);
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    check_eq("clr2_err", err, 0);

    // Disabled steps decode silently.
    step_seen = 0;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin set_ab(upseq[i]); hold(8); end
    check_eq("dis_steps", step_seen, 0);
    check_eq("dis_count", count, 12);
    enable = 1'b1;
    set_ab(2'b00);
    hold(8);
    check_eq("en_steps", step_seen, 1);
    check_eq("en_count", count, 13);

    // Load coinciding with a step.
    set_ab(2'b10);
    hold(4);
    load = 1'b1; data_in = 4'd9;
    cyc();
    load = 1'b0;
    check_eq("load_step", step, 1);
    check_eq("load_count", count, 9);
    hold(6);

    // 2-cycle glitch on A.
    step_seen = 0;
    set_ab(2'b00); hold(2);
    set_ab(2'b10); hold(8);
    check_eq("glitch_steps", step_seen, 0);
    check_eq("glitch_err", err, 0);
    check_eq("glitch_count", count, 9);

    // Mid-operation reset, re-prime at a non-zero level.
    set_ab(2'b11); hold(8);
    check_eq("pre_rst_count", count, 10);
    step_seen = 0;
    do_reset(3);
    set_ab(2'b01);
    hold(12);
    check_eq("reprime_steps", step_seen, 0);
    check_eq("reprime_count", count, 0);

    // Randomised walk against the model.
    p = 3;
    for (int s = 0; s < 300; s++) begin
      enable = ($urandom_range(0, 99) < 85);
      r = $urandom_range(0, 99);
      if (r < 70) begin
        p = ($urandom_range(0, 1) != 0) ? p + 1 : p + 3;
        set_ab(genc(p));
        repeat ($urandom_range(4, 12)) rcyc();
      end else if (r < 80) begin
        p = p + 2;
        set_ab(genc(p));
        repeat (6) rcyc();
      end else if (r < 96) begin
        g = $urandom_range(1, 2);
        set_ab(genc(p) ^ 2'b10);
        repeat (g) rcyc();
        set_ab(genc(p));
        repeat (6) rcyc();
      end else begin
        load = 1'b0; err_clr = 1'b0;
        do_reset(2);
        repeat (8) rcyc();
      end
    end
    load = 1'b0; err_clr = 1'b0;
    hold(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
